// File: rtl/mem_bus_arbiter_np.sv
// N-port shared-memory arbiter: independent round-robin read and write channels with RAW protection.
// Optional SNOOP_EN macro enables the registered snoop-invalidate broadcast on write grants.
module mem_bus_arbiter_np #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int PTR_W     = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS-1:0]          req,
    input  logic [NUM_PORTS-1:0]          we,
    input  logic [NUM_PORTS*ADDR_W-1:0]   addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   wdata,
    output logic [NUM_PORTS-1:0]          done,
    output logic [DATA_W-1:0]             rdata,
    output logic                          mem_rd_en,
    output logic [ADDR_W-1:0]             mem_rd_addr,
    input  logic [DATA_W-1:0]             mem_rd_data,
    input  logic                          mem_rd_done,
    output logic                          mem_wr_en,
    output logic [ADDR_W-1:0]             mem_wr_addr,
    output logic [DATA_W-1:0]             mem_wr_data,
    input  logic                          mem_wr_done,
    output logic                          snoop_valid,
    output logic [ADDR_W-1:0]             snoop_addr,
    output logic [PTR_W-1:0]              snoop_src
);

    function automatic logic [PTR_W-1:0] wrap_idx(input int v);
        return PTR_W'(v % NUM_PORTS);
    endfunction

    logic                 r_rd_busy, r_wr_busy;
    logic [PTR_W-1:0]     r_rd_port, r_wr_port, r_rd_ptr, r_wr_ptr;
    logic [ADDR_W-1:0]    r_rd_addr, r_wr_addr;
    logic [DATA_W-1:0]    r_wr_data, r_rdata;
    logic [NUM_PORTS-1:0] r_done;

    logic [NUM_PORTS-1:0] w_elig;
    logic                 w_wr_gnt, w_rd_gnt, w_rd_skip;
    logic [PTR_W-1:0]     w_wr_sel, w_rd_sel, w_rd_skip_sel, w_k;
    logic [ADDR_W-1:0]    w_k_addr, w_wr_gnt_addr, w_rd_gnt_addr;

    always_comb begin
        w_elig = '0;
        for (int p = 0; p < NUM_PORTS; p++)
            w_elig[p] = req[p] && !r_done[p]
                        && !(r_rd_busy && r_rd_port == PTR_W'(p))
                        && !(r_wr_busy && r_wr_port == PTR_W'(p));
    end

    // Write arbitration runs first so a read to the same address can yield on the same edge.
    always_comb begin
        w_wr_gnt      = 1'b0;
        w_wr_sel      = '0;
        w_rd_gnt      = 1'b0;
        w_rd_sel      = '0;
        w_rd_skip     = 1'b0;
        w_rd_skip_sel = '0;
        w_k           = '0;
        w_k_addr      = '0;
        if (!r_wr_busy) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                w_k = wrap_idx(int'(r_wr_ptr) + i);
                if (!w_wr_gnt && w_elig[w_k] && we[w_k]) begin
                    w_wr_gnt = 1'b1;
                    w_wr_sel = w_k;
                end
            end
        end
        w_wr_gnt_addr = addr[w_wr_sel*ADDR_W +: ADDR_W];
        if (!r_rd_busy) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                w_k      = wrap_idx(int'(r_rd_ptr) + i);
                w_k_addr = addr[w_k*ADDR_W +: ADDR_W];
                if (!w_rd_gnt && w_elig[w_k] && !we[w_k]) begin
                    if ((r_wr_busy && w_k_addr == r_wr_addr) ||
                        (w_wr_gnt && w_k_addr == w_wr_gnt_addr)) begin
                        if (!w_rd_skip) begin
                            w_rd_skip     = 1'b1;
                            w_rd_skip_sel = w_k;
                        end
                    end else begin
                        w_rd_gnt = 1'b1;
                        w_rd_sel = w_k;
                    end
                end
            end
        end
        w_rd_gnt_addr = addr[w_rd_sel*ADDR_W +: ADDR_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_busy <= 1'b0;
            r_wr_busy <= 1'b0;
            r_rd_port <= '0;
            r_wr_port <= '0;
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_rd_addr <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_rdata   <= '0;
            r_done    <= '0;
        end else begin
            r_done <= '0;
            if (r_rd_busy && mem_rd_done) begin
                r_rd_busy         <= 1'b0;
                r_done[r_rd_port] <= 1'b1;
                r_rdata           <= mem_rd_data;
            end else if (w_rd_gnt) begin
                r_rd_busy <= 1'b1;
                r_rd_port <= w_rd_sel;
                r_rd_addr <= w_rd_gnt_addr;
                // A skipped hazard port keeps first claim on the next search.
                r_rd_ptr  <= w_rd_skip ? w_rd_skip_sel : wrap_idx(int'(w_rd_sel) + 1);
            end
            if (r_wr_busy && mem_wr_done) begin
                r_wr_busy         <= 1'b0;
                r_done[r_wr_port] <= 1'b1;
            end else if (w_wr_gnt) begin
                r_wr_busy <= 1'b1;
                r_wr_port <= w_wr_sel;
                r_wr_addr <= w_wr_gnt_addr;
                r_wr_data <= wdata[w_wr_sel*DATA_W +: DATA_W];
                r_wr_ptr  <= wrap_idx(int'(w_wr_sel) + 1);
            end
        end
    end

    assign done        = r_done;
    assign rdata       = r_rdata;
    assign mem_rd_en   = r_rd_busy;
    assign mem_rd_addr = r_rd_addr;
    assign mem_wr_en   = r_wr_busy;
    assign mem_wr_addr = r_wr_addr;
    assign mem_wr_data = r_wr_data;

`ifdef SNOOP_EN
    logic              r_snp_valid;
    logic [ADDR_W-1:0] r_snp_addr;
    logic [PTR_W-1:0]  r_snp_src;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_snp_valid <= 1'b0;
            r_snp_addr  <= '0;
            r_snp_src   <= '0;
        end else begin
            r_snp_valid <= w_wr_gnt;
            if (w_wr_gnt) begin
                r_snp_addr <= w_wr_gnt_addr;
                r_snp_src  <= w_wr_sel;
            end
        end
    end

    assign snoop_valid = r_snp_valid;
    assign snoop_addr  = r_snp_addr;
    assign snoop_src   = r_snp_src;
`else
    assign snoop_valid = 1'b0;
    assign snoop_addr  = '0;
    assign snoop_src   = '0;
`endif

endmodule
